// File: rtl/fetch_unit.sv
// fetch_unit -- PC / IR / MDR holder and unified memory port arbiter for the
// multicycle MIPS core. Sits directly downstream of the control sequencer.
//
// An instruction fetch (ir_write_i) takes priority over a data access
// (i_or_d_i). Memory wait states raise stall_o so the sequencer holds its
// strobes. A watchdog counts unanswered wait cycles and parks the block in a
// sticky error state that only reset leaves.
//
// Optional feature macro: FETCH_PERF_CNT_EN. When it is defined, fetch and
// stall counters drive fetch_cnt_o / stall_cnt_o. When it is undefined, both
// ports are tied to zero and no counter flops exist.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   TIMEOUT_CYC  wait cycles tolerated before bus error (1..65535)
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   pc_write_i           unconditional PC load
//   ir_write_i           instruction fetch request / IR load
//   i_or_d_i             data access request (address from alu_out_i)
//   mem_write_i          data access is a store
//   pc_src_i[1:0]        next-PC select
//   branch_i, zero_i     conditional PC load (taken when zero_i=1)
//   alu_result_i         combinational ALU output
//   alu_out_i            registered ALUOut
//   wr_data_i            store data
//   mem_req_o            memory access valid
//   mem_we_o             store qualifier
//   mem_addr_o           byte address
//   mem_wdata_o          store data
//   mem_rdata_i          read data, valid with mem_ready_i
//   mem_ready_i          access completes this cycle
//   pc_o, instr_o, op_o  current PC, IR, IR opcode field
//   mdr_o                last data-read result
//   stall_o              hold sequencer this cycle
//   bus_err_o            sticky watchdog error
//   fetch_cnt_o          completed instruction fetches (perf build)
//   stall_cnt_o          stalled cycles (perf build)
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write_i,
  input  logic        ir_write_i,
  input  logic        i_or_d_i,
  input  logic        mem_write_i,
  input  logic [1:0]  pc_src_i,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] wr_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [5:0]  op_o,
  output logic [31:0] mdr_o,
  output logic        stall_o,
  output logic        bus_err_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;

  logic acc;
  logic done;
  logic req;
  logic stall;
  logic pc_ld;

  assign acc = ir_write_i | i_or_d_i;

  // Access FSM: request/stall generation and watchdog.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req   = acc;
        stall = acc & ~mem_ready_i;
        if (acc) begin
          if (mem_ready_i) begin
            done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        req   = 1'b1;
        stall = acc & ~mem_ready_i;
        if (mem_ready_i) begin
          // A response on the timeout cycle still wins over the watchdog.
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (({1'b0, cnt_q} + 17'd1) == TO_LIM) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Reset masks the port and the stall immediately, aborting any access.
    if (!reset) begin
      req   = 1'b0;
      stall = 1'b0;
      done  = 1'b0;
    end
  end

  // Datapath next-state.
  always_comb begin
    ir_d  = ir_q;
    mdr_d = mdr_q;
    pc_d  = pc_q;
    if (done && ir_write_i) begin
      ir_d = mem_rdata_i;
    end
    if (done && i_or_d_i && !ir_write_i && !mem_write_i) begin
      mdr_d = mem_rdata_i;
    end
    if (pc_ld) begin
      case (pc_src_i)
        2'b00:   pc_d = alu_result_i;
        2'b01:   pc_d = alu_out_i;
        2'b10:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        default: pc_d = pc_q;
      endcase
    end
  end

  // The PC only moves on a non-stalled edge, so a fetch that also increments
  // the PC addresses memory with the old value throughout its wait states.
  assign pc_ld = (pc_write_i | (branch_i & zero_i)) & ~stall & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

  assign mem_req_o   = req;
  assign mem_we_o    = req & ~ir_write_i & mem_write_i;
  assign mem_addr_o  = ir_write_i ? pc_q : alu_out_i;
  assign mem_wdata_o = wr_data_i;
  assign pc_o        = pc_q;
  assign instr_o     = ir_q;
  assign op_o        = ir_q[31:26];
  assign mdr_o       = mdr_q;
  assign stall_o     = stall;
  assign bus_err_o   = (state_q == S_ERR);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] scnt_q, scnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    scnt_d = scnt_q;
    if (done && ir_write_i) fcnt_d = fcnt_q + 32'd1;
    if (stall)              scnt_d = scnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign fetch_cnt_o = fcnt_q;
  assign stall_cnt_o = scnt_q;
`else
  assign fetch_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// wait/watchdog/perf sequences, then randomized traffic against a
// transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int          T   = 4;
  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;

  logic        clk, reset;
  logic        pc_write, ir_write, i_or_d, mem_write, branch, zero;
  logic [1:0]  pc_src;
  logic [31:0] alu_result, alu_out, wr_data, mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, stall, bus_err;
  logic [31:0] mem_addr, mem_wdata, pc, instr, mdr, fetch_cnt, stall_cnt;
  logic [5:0]  op;

  fetch_unit #(.RESET_PC(RPC), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset),
    .pc_write_i(pc_write), .ir_write_i(ir_write), .i_or_d_i(i_or_d),
    .mem_write_i(mem_write), .pc_src_i(pc_src), .branch_i(branch),
    .zero_i(zero), .alu_result_i(alu_result), .alu_out_i(alu_out),
    .wr_data_i(wr_data), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready), .pc_o(pc), .instr_o(instr), .op_o(op),
    .mdr_o(mdr), .stall_o(stall), .bus_err_o(bus_err),
    .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    pc_write = L; ir_write = L; i_or_d = L; mem_write = L; branch = L; zero = L;
    pc_src = 2'd0; alu_result = '0; alu_out = '0; wr_data = '0;
    mem_rdata = '0; mem_ready = L;
  endtask

  task automatic do_reset;
    idle_in();
    reset = L;
    tick();
    reset = H;
  endtask

  typedef struct {
    logic        ir, pw, iod, mw;
    logic [1:0]  src;
    logic        br, z;
    logic [31:0] alu_r, alu_o, wd, rd;
    logic        req, we, stl;
    logic [31:0] addr, pc, instr, mdr;
  } vec_t;

  vec_t vt [8];

  // Reference model state
  logic [31:0] m_pc, m_ir, m_mdr, m_fc, m_sc;
  logic        m_err;
  int          m_wait;

  initial begin
    logic        hold, rst_now, e_req, e_stall, acc, pcld;
    logic [31:0] ef, es;

    vt[0] = '{H,H,L,L,2'd0,L,L, 32'h00400004, 32'h0, 32'h0, 32'h2009000A,
              H,L,L, 32'h00400000, 32'h00400004, 32'h2009000A, 32'h0};
    vt[1] = '{L,L,H,L,2'd0,L,L, 32'h0, 32'h10010000, 32'h0, 32'hDEADBEEF,
              H,L,L, 32'h10010000, 32'h00400004, 32'h2009000A, 32'hDEADBEEF};
    vt[2] = '{L,L,H,H,2'd0,L,L, 32'h0, 32'h10010004, 32'h5, 32'h12345678,
              H,H,L, 32'h10010004, 32'h00400004, 32'h2009000A, 32'hDEADBEEF};
    vt[3] = '{H,H,L,L,2'd0,L,L, 32'h00400008, 32'h0, 32'h0, 32'h08100004,
              H,L,L, 32'h00400004, 32'h00400008, 32'h08100004, 32'hDEADBEEF};
    vt[4] = '{L,H,L,L,2'd2,L,L, 32'h0, 32'h0, 32'h0, 32'h0,
              L,L,L, 32'h0, 32'h00400010, 32'h08100004, 32'hDEADBEEF};
    vt[5] = '{L,L,L,L,2'd1,H,L, 32'h0, 32'h12340000, 32'h0, 32'h0,
              L,L,L, 32'h0, 32'h00400010, 32'h08100004, 32'hDEADBEEF};
    vt[6] = '{L,L,L,L,2'd1,H,H, 32'h0, 32'h00400100, 32'h0, 32'h0,
              L,L,L, 32'h0, 32'h00400100, 32'h08100004, 32'hDEADBEEF};
    vt[7] = '{L,H,L,L,2'd3,L,L, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
              L,L,L, 32'h0, 32'h00400100, 32'h08100004, 32'hDEADBEEF};

    // Reset state, with a fetch request held during reset to show masking.
    idle_in();
    reset = L;
    tick();
    ir_write = H;
    #1;
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    tick();
    chk("rst_pc", pc, RPC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_op", {26'h0, op}, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_err", {31'h0, bus_err}, 32'h0);
    idle_in();
    reset = H;

    // Directed zero-wait vectors.
    for (int i = 0; i < 8; i++) begin
      ir_write = vt[i].ir; pc_write = vt[i].pw; i_or_d = vt[i].iod;
      mem_write = vt[i].mw; pc_src = vt[i].src; branch = vt[i].br;
      zero = vt[i].z; alu_result = vt[i].alu_r; alu_out = vt[i].alu_o;
      wr_data = vt[i].wd; mem_rdata = vt[i].rd; mem_ready = H;
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, mem_req}, {31'h0, vt[i].req});
      chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vt[i].stl});
      if (vt[i].req) begin
        chk($sformatf("v%0d_addr", i), mem_addr, vt[i].addr);
        chk($sformatf("v%0d_we", i), {31'h0, mem_we}, {31'h0, vt[i].we});
      end
      if (vt[i].we) chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].wd);
      tick();
      chk($sformatf("v%0d_pc", i), pc, vt[i].pc);
      chk($sformatf("v%0d_instr", i), instr, vt[i].instr);
      chk($sformatf("v%0d_op", i), {26'h0, op}, {26'h0, vt[i].instr[31:26]});
      chk($sformatf("v%0d_mdr", i), mdr, vt[i].mdr);
    end

    // Fetch with three wait states.
    do_reset();
    ir_write = H; pc_write = H; alu_result = 32'h00400004;
    mem_rdata = 32'h2009000A; mem_ready = L;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w3_stall", {31'h0, stall}, 32'h1);
      chk("w3_addr", mem_addr, RPC);
      tick();
      chk("w3_pc_hold", pc, RPC);
      chk("w3_ir_hold", instr, 32'h0);
    end
    mem_ready = H;
    #1;
    chk("w3_stall_end", {31'h0, stall}, 32'h0);
    tick();
    chk("w3_pc", pc, 32'h00400004);
    chk("w3_instr", instr, 32'h2009000A);
    idle_in();

    // Response exactly on the timeout cycle completes the access.
    do_reset();
    ir_write = H; mem_rdata = 32'hCAFE0001; mem_ready = L;
    for (int i = 0; i < T; i++) tick();
    mem_ready = H;
    tick();
    idle_in();
    #1;
    chk("tocyc_err", {31'h0, bus_err}, 32'h0);
    chk("tocyc_instr", instr, 32'hCAFE0001);
    chk("tocyc_stall", {31'h0, stall}, 32'h0);

    // Watchdog expiry and recovery by reset.
    do_reset();
    ir_write = H; pc_write = H; alu_result = 32'h00400004; mem_ready = L;
    for (int i = 0; i <= T; i++) begin
      #1;
      chk("wd_req", {31'h0, mem_req}, 32'h1);
      chk("wd_stall", {31'h0, stall}, 32'h1);
      tick();
    end
    chk("wd_err", {31'h0, bus_err}, 32'h1);
    chk("wd_req_off", {31'h0, mem_req}, 32'h0);
    chk("wd_stall_err", {31'h0, stall}, 32'h1);
    mem_ready = H;
    tick();
    chk("wd_sticky", {31'h0, bus_err}, 32'h1);
    chk("wd_pc_frozen", pc, RPC);
    reset = L;
    #1;
    chk("wd_rst_req", {31'h0, mem_req}, 32'h0);
    chk("wd_rst_stall", {31'h0, stall}, 32'h0);
    tick();
    reset = H;
    chk("wd_rst_err", {31'h0, bus_err}, 32'h0);
    chk("wd_rst_pc", pc, RPC);
    idle_in();

    // Perf counters: three fetches, one of them with two wait states.
    do_reset();
    ir_write = H; mem_ready = H;
    tick();
    mem_ready = L;
    tick();
    tick();
    mem_ready = H;
    tick();
    tick();
    idle_in();
`ifdef FETCH_PERF_CNT_EN
    ef = 32'd3; es = 32'd2;
`else
    ef = 32'd0; es = 32'd0;
`endif
    chk("perf_fetch", fetch_cnt, ef);
    chk("perf_stall", stall_cnt, es);

    // Randomized traffic against the reference model.
    do_reset();
    m_pc = RPC; m_ir = '0; m_mdr = '0; m_err = 1'b0; m_wait = 0;
    m_fc = '0; m_sc = '0;
    hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        case ($urandom % 4)
          0: begin ir_write = H; i_or_d = 1'($urandom); end
          1: begin ir_write = L; i_or_d = H; end
          2: begin ir_write = L; i_or_d = H; end
          default: begin ir_write = L; i_or_d = L; end
        endcase
        mem_write  = 1'($urandom);
        pc_write   = 1'($urandom);
        branch     = 1'($urandom);
        zero       = 1'($urandom);
        pc_src     = 2'($urandom);
        alu_result = $urandom;
        alu_out    = $urandom;
        wr_data    = $urandom;
      end
      rst_now   = m_err ? ($urandom % 4 == 0) : ($urandom % 64 == 0);
      reset     = ~rst_now;
      mem_ready = ($urandom % 3) != 0;
      mem_rdata = $urandom;
      #1;
      acc = ir_write | i_or_d;
      if (rst_now) begin
        e_req = 1'b0; e_stall = 1'b0;
      end else if (m_err) begin
        e_req = 1'b0; e_stall = 1'b1;
      end else begin
        e_req = acc | (m_wait > 0); e_stall = acc & ~mem_ready;
      end
      chk("r_req", {31'h0, mem_req}, {31'h0, e_req});
      chk("r_stall", {31'h0, stall}, {31'h0, e_stall});
      if (!e_req) begin
        if (rst_now) chk("r_we_rst", {31'h0, mem_we}, 32'h0);
      end else begin
        chk("r_addr", mem_addr, ir_write ? m_pc : alu_out);
        chk("r_we", {31'h0, mem_we}, {31'h0, ~ir_write & mem_write});
        if (!ir_write && mem_write) chk("r_wdata", mem_wdata, wr_data);
      end
      // Advance the model by one cycle.
      if (rst_now) begin
        m_pc = RPC; m_ir = '0; m_mdr = '0; m_err = 1'b0; m_wait = 0;
        m_fc = '0; m_sc = '0;
      end else begin
        pcld = (pc_write | (branch & zero)) & ~e_stall;
        if (pcld) begin
          case (pc_src)
            2'd0: m_pc = alu_result;
            2'd1: m_pc = alu_out;
            2'd2: m_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
            default: ;
          endcase
        end
        if (e_stall) m_sc = m_sc + 32'd1;
        if (!m_err && acc) begin
          if (mem_ready) begin
            if (ir_write) begin
              m_ir = mem_rdata; m_fc = m_fc + 32'd1;
            end else if (!mem_write) begin
              m_mdr = mem_rdata;
            end
            m_wait = 0;
          end else begin
            m_wait++;
            if (m_wait == T + 1) m_err = 1'b1;
          end
        end
      end
      hold = e_stall & ~rst_now;
      tick();
      chk("r_pc", pc, m_pc);
      chk("r_instr", instr, m_ir);
      chk("r_op", {26'h0, op}, {26'h0, m_ir[31:26]});
      chk("r_mdr", mdr, m_mdr);
      chk("r_err", {31'h0, bus_err}, {31'h0, m_err});
`ifdef FETCH_PERF_CNT_EN
      chk("r_fcnt", fetch_cnt, m_fc);
      chk("r_scnt", stall_cnt, m_sc);
`else
      chk("r_fcnt0", fetch_cnt, 32'h0);
      chk("r_scnt0", stall_cnt, 32'h0);
`endif
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
